// File: rtl/iram_reader.sv
// iram_reader: burst reader that fetches `length` consecutive bytes from an
// IRAM with one-cycle read latency and streams them out over a valid/ready
// handshake through a two-entry buffer. Reads are only issued when the data
// coming back is guaranteed a free buffer slot, so nothing is ever dropped.
module iram_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              iram_rden,
  output logic [ADDR_W-1:0] IRAM_address,
  input  logic [DATA_W-1:0] iram_q,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [2:0]        DEPTH_C   = 3'(DEPTH);

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   remaining_r;
  logic              inflight_r;
  logic [DATA_W-1:0] buf_r [0:1];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic              issue_s;
  logic              pop_s;
  logic              flush_s;
  logic              raw_pop_s;
  logic [2:0]        occupancy_s;
  logic [DATA_W-1:0] out_data_s;

  // Buffer occupancy as seen after this cycle's pop, counting the read whose data is still on its way.
  assign raw_pop_s   = (count_r != 2'd0) && out_ready;
  assign occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, raw_pop_s};

  // Next-state decode plus the per-cycle issue/pop/flush strobes; abort overrides pop and issue.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (length != LEN_ZERO) begin
            state_next_s = READ;
          end else begin
            state_next_s = DONE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          flush_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          pop_s   = raw_pop_s;
          issue_s = (remaining_r != LEN_ZERO) && (occupancy_s < DEPTH_C);
          if (issue_s && (remaining_r == LEN_ONE)) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = READ;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          flush_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          pop_s = raw_pop_s;
          if (pop_s && (count_r == 2'd1) && !inflight_r) begin
            state_next_s = DONE;
          end else begin
            state_next_s = DRAIN;
          end
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register plus registered busy/done flags derived from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == READ) || (state_next_s == DRAIN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Next read address and number of reads still to issue for the current burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= ADDR_ZERO;
      remaining_r <= LEN_ZERO;
    end else if (accept_s) begin
      addr_r      <= base_addr;
      remaining_r <= length;
    end else if (flush_s) begin
      remaining_r <= LEN_ZERO;
    end else if (issue_s) begin
      addr_r      <= addr_r + ADDR_ONE;
      remaining_r <= remaining_r - LEN_ONE;
    end
  end

  // Marks that IRAM data for last cycle's read arrives this cycle; abort discards it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_r <= 1'b0;
    end else if (flush_s) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
    end
  end

  // Two-entry FIFO holding returned bytes in address order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_r[0] <= DATA_ZERO;
      buf_r[1] <= DATA_ZERO;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush_s) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (inflight_r) begin
        buf_r[wr_ptr_r] <= iram_q;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  // Present the oldest entry; drive zero when the buffer is empty so stale bytes never leak.
  always_comb begin
    out_data_s = DATA_ZERO;
    if (count_r != 2'd0) begin
      out_data_s = buf_r[rd_ptr_r];
    end else begin
      out_data_s = DATA_ZERO;
    end
  end

  assign iram_rden    = issue_s;
  assign IRAM_address = addr_r;
  assign out_valid    = (count_r != 2'd0);
  assign out_data     = out_data_s;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_iram_reader.sv
// Testbench for iram_reader: a behavioural IRAM (random contents, one-cycle
// latency) plus a scoreboard that expects bytes mem[(base+i) mod 256] in order,
// one address per issued read, at most two bytes outstanding, and a stable
// output while the consumer stalls.
module tb_iram_reader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'd0;
  logic [8:0] length = 9'd0;
  logic       abort = 1'b0;
  logic       iram_rden;
  logic [7:0] IRAM_address;
  logic [7:0] iram_q = 8'd0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  int ready_mode = 1;

  // scoreboard state
  int         cyc = 0;
  bit         active = 1'b0;
  bit         hold = 1'b0;
  logic [7:0] hold_data = 8'd0;
  logic [7:0] exp_base = 8'd0;
  int         exp_len = 0;
  int         issued = 0;
  int         accepted = 0;
  int         done_cnt = 0;
  int         start_cyc = 0;
  int         first_rden = -1;
  int         first_valid = -1;
  int         first_acc = -1;
  int         last_acc = -1;
  int         done_cyc = -1;
  bit         busy_seen = 1'b0;
  logic [7:0] addr_log [$];
  logic [7:0] ea;
  logic [7:0] ed;

  iram_reader #(.ADDR_W(8), .DATA_W(8), .DEPTH(2)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .abort(abort),
    .iram_rden(iram_rden),
    .IRAM_address(IRAM_address),
    .iram_q(iram_q),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // IRAM model: data for a read strobed in one cycle appears in the next cycle.
  initial begin
    logic       p;
    logic [7:0] a;
    forever begin
      @(negedge clock);
      p = iram_rden;
      a = IRAM_address;
      @(posedge clock);
      #1;
      if (p) iram_q = mem[a];
      else   iram_q = 8'($urandom);
    end
  end

  // Consumer: always ready, never ready, or ready about 3/4 of the time.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Scoreboard, evaluated mid-cycle when every DUT output is settled.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      active = 1'b0;
      hold   = 1'b0;
    end else begin
      if (!active) begin
        chk("idle_valid", int'(out_valid), 0);
        chk("idle_rden", int'(iram_rden), 0);
      end
      if (start && !busy && !done) begin
        active      = 1'b1;
        exp_base    = base_addr;
        exp_len     = int'(length);
        issued      = 0;
        accepted    = 0;
        start_cyc   = cyc;
        first_rden  = -1;
        first_valid = -1;
        first_acc   = -1;
        last_acc    = -1;
        done_cyc    = -1;
        busy_seen   = 1'b0;
        hold        = 1'b0;
        addr_log.delete();
      end
      if (busy) busy_seen = 1'b1;
      if (abort && busy) begin
        chk("abort_rden", int'(iram_rden), 0);
        active = 1'b0;
        hold   = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_data", int'(out_data), int'(hold_data));
        end
        if (iram_rden) begin
          addr_log.push_back(IRAM_address);
          if (first_rden < 0) first_rden = cyc;
          ea = exp_base + 8'(issued);
          chk("rd_addr", int'(IRAM_address), int'(ea));
          issued++;
          chk("rd_within_len", int'(issued <= exp_len), 1);
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
          ed = mem[exp_base + 8'(accepted)];
          chk("data", int'(out_data), int'(ed));
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          accepted++;
        end
        if (iram_rden) chk("outstanding", int'((issued - accepted) <= 2), 1);
        hold      = out_valid && !out_ready;
        hold_data = out_data;
        if (done) begin
          chk("done_in_burst", int'(active), 1);
          chk("done_len", accepted, exp_len);
          done_cnt++;
          done_cyc = cyc;
          active   = 1'b0;
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(posedge clock);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    chk("done_seen", int'(done_cnt != d0), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rden"}, int'(iram_rden), 0);
    chk({tag, "_addr"}, int'(IRAM_address), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0;
    int         n;
    logic [7:0] b;
    logic [8:0] l;
    logic [7:0] exp_seq [4];

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // reset state
    #3;
    check_zero("reset");
    #10;
    reset_n = 1'b1;

    // base 0x10, length 4, consumer always ready
    ready_mode = 1;
    d0 = done_cnt;
    do_start(8'h10, 9'd4);
    wait_done(40);
    chk("lat_rden", first_rden - start_cyc, 1);
    chk("lat_valid", first_valid - first_rden, 2);
    chk("b2b_span", last_acc - first_acc, 3);
    chk("b2b_count", accepted, 4);
    chk("done_after_last", done_cyc - last_acc, 1);
    repeat (4) @(posedge clock);
    #1;
    chk("done_once", done_cnt - d0, 1);

    // address wrap FE, FF, 00, 01
    do_start(8'hFE, 9'd4);
    wait_done(40);
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    chk("wrap_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("wrap_addr", int'(addr_log[i]), int'(exp_seq[i]));

    // consumer stalled for 5 cycles
    ready_mode = 0;
    do_start(8'($urandom), 9'd3);
    repeat (5) begin
      @(negedge clock);
      #2;
    end
    chk("stall_reads", issued, 2);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_accepted", accepted, 0);
    ready_mode = 1;
    wait_done(40);
    chk("stall_all_bytes", accepted, 3);

    // zero-length burst
    d0 = done_cnt;
    do_start(8'($urandom), 9'd0);
    wait_done(10);
    chk("len0_done_cyc", done_cyc - start_cyc, 1);
    chk("len0_reads", issued, 0);
    chk("len0_busy", int'(busy_seen), 0);
    chk("len0_done_cnt", done_cnt - d0, 1);

    // 256-byte burst aborted after 10 bytes, immediate restart
    d0 = done_cnt;
    do_start(8'($urandom), 9'd256);
    n = 0;
    while (accepted < 10 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    chk("abort_reached10", int'(accepted >= 10), 1);
    @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort     = 1'b0;
    start     = 1'b1;
    base_addr = 8'($urandom);
    length    = 9'd5;
    @(negedge clock);
    #2;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_done", int'(done), 0);
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(60);
    chk("restart_bytes", accepted, 5);
    chk("abort_done_cnt", done_cnt - d0, 1);

    // randomized bursts with a random consumer
    ready_mode = 2;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      l = (k % 4 == 0) ? 9'd1 : 9'($urandom_range(2, 24));
      d0 = done_cnt;
      do_start(b, l);
      wait_done(int'(l) * 10 + 40);
      chk("rand_bytes", accepted, int'(l));
      chk("rand_done_cnt", done_cnt - d0, 1);
    end

    // full 256-byte burst, full throughput
    ready_mode = 1;
    do_start(8'h80, 9'd256);
    wait_done(400);
    chk("full_bytes", accepted, 256);
    chk("full_span", last_acc - first_acc, 255);

    // asynchronous reset mid-burst
    ready_mode = 2;
    do_start(8'($urandom), 9'd40);
    repeat (8) @(posedge clock);
    #3;
    chk("midreset_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    ready_mode = 1;
    do_start(8'($urandom), 9'd6);
    wait_done(60);
    chk("postreset_bytes", accepted, 6);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iram_reader.md
IRAM_READER -- requirements
Module: iram_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, IRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, IRAM/stream data width.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries (fixed at 2; other values unsupported).
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports clock and reset_n, listed first.
REQ-005 SHALL have port clock  input  1  rising-edge system clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a burst read.
REQ-008 SHALL have port base_addr  input  ADDR_W  first IRAM address; sampled with start.
REQ-009 SHALL have port length  input  ADDR_W+1  bytes to read, 0..256; sampled with start.
REQ-010 SHALL have port abort  input  1  cancel the current burst.
REQ-011 SHALL have port iram_rden  output  1  IRAM read strobe.
REQ-012 SHALL have port IRAM_address  output  ADDR_W  IRAM read address.
REQ-013 SHALL have port iram_q  input  DATA_W  IRAM read data, valid the cycle after iram_rden.
REQ-014 SHALL have port out_valid  output  1  out_data holds a byte.
REQ-015 SHALL have port out_data  output  DATA_W  streamed byte.
REQ-016 SHALL have port out_ready  input  1  consumer accepts the byte.
REQ-017 SHALL have port busy  output  1  burst in progress.
REQ-018 SHALL have port done  output  1  one-cycle burst-complete pulse.

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-020 SHALL, in IDLE, on start=1 with length>0, latch base_addr/length and go to READ; with length=0, go to DONE (no reads).
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL, in READ, assert iram_rden when remaining>0 and (buffer count + in-flight reads - pop this cycle) < DEPTH.
REQ-023 SHALL drive IRAM_address = (base_addr + issued count) mod 2^ADDR_W, wrapping 255 -> 0.
REQ-024 SHALL write iram_q into the buffer on the edge ending the cycle after each iram_rden.
REQ-025 SHALL assert out_valid whenever the buffer is non-empty; out_data SHALL be the oldest entry, in address order.
REQ-026 SHALL pop one entry on each cycle with out_valid=1 and out_ready=1.
REQ-027 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-028 SHALL sustain one byte per cycle when out_ready is held at 1.
REQ-029 SHALL give first-byte latency as follows: start sampled at edge E0 -> iram_rden high in cycle after E0 -> out_valid high after E2.
REQ-030 SHALL go READ -> DRAIN once all length reads are issued, and DRAIN -> DONE on the edge where the last byte is accepted.
REQ-031 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-032 SHALL make busy=1 in READ and DRAIN only.
REQ-033 SHALL, on abort=1 in READ or DRAIN, go to IDLE next edge, flush the buffer, discard in-flight data, and not pulse done; abort SHALL be ignored in IDLE and DONE.
REQ-034 SHALL give abort priority over a same-cycle pop and a same-cycle read issue.

Reset
REQ-035 SHALL, on reset_n=0 at any time (including mid-burst), asynchronously force: state IDLE, buffer empty, in-flight cleared; iram_rden=0, IRAM_address=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-036 SHALL resume normal operation on the first rising clock edge after reset_n returns to 1.

Verification
REQ-037 SHALL cover: base_addr=0x10, length=4, out_ready=1 -> bytes from 0x10..0x13 on 4 consecutive cycles; first out_valid 2 cycles after first iram_rden; done pulses once.
REQ-038 SHALL cover: base_addr=0xFE, length=4 -> IRAM_address sequence FE, FF, 00, 01.
REQ-039 SHALL cover: length=3, out_ready=0 for 5 cycles -> at most 2 reads issued, out_data stable; after out_ready=1 all 3 bytes arrive in order with none lost.
REQ-040 SHALL cover: length=0 -> no iram_rden, done one cycle after start, busy stays 0.
REQ-041 SHALL cover: length=256, abort after 10 accepted bytes -> IDLE next cycle, out_valid=0, no done pulse, and a new start is accepted immediately.
REQ-042 SHALL cover: reset_n pulsed low mid-burst between clock edges -> all outputs zero immediately; start then works normally.
